// File: rtl/c4_turn_controller.sv
// Connect Four turn sequencer: turns keycodes into one-hot column drops, alternates colours,
// waits for the win checker and ends the game on a win or a full board.
module c4_turn_controller #(
    parameter int unsigned CHECK_CYCLES = 2,
    parameter logic [7:0]  KEY_COL0     = 8'h1E,
    parameter logic [7:0]  KEY_NEWGAME  = 8'h28
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [6:0] col_full,
    input  logic       win_flag,
    output logic [6:0] drop_req,
    output logic       drop_black,
    output logic       turn_black,
    output logic [5:0] move_count,
    output logic       invalid_move,
    output logic       board_clear,
    output logic       game_over,
    output logic       winner_black,
    output logic       draw
);

    typedef enum logic [2:0] {
        StReady,
        StDrop,
        StSettle,
        StEval,
        StDone
    } state_e;

    localparam logic [3:0] LastWait = 4'(CHECK_CYCLES - 1);
    localparam logic [5:0] MaxMoves = 6'd42;

    state_e     state_q;
    logic       armed_q;
    logic [3:0] wait_q;

    logic [8:0] key_off;
    logic       key_is_col;
    logic [2:0] key_col;
    logic       key_idle;
    logic       key_newgame;
    logic       col_blocked;

    // Nine-bit difference so keycodes below KEY_COL0 wrap far above the column range.
    always_comb begin
        key_off     = {1'b0, keycode} - {1'b0, KEY_COL0};
        key_is_col  = key_off < 9'd7;
        key_col     = key_off[2:0];
        key_idle    = keycode == 8'h00;
        key_newgame = keycode == KEY_NEWGAME;
        col_blocked = col_full[key_col];
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q      <= StReady;
            armed_q      <= 1'b0;
            wait_q       <= '0;
            drop_req     <= '0;
            drop_black   <= 1'b0;
            turn_black   <= 1'b0;
            move_count   <= '0;
            invalid_move <= 1'b0;
            board_clear  <= 1'b0;
            game_over    <= 1'b0;
            winner_black <= 1'b0;
            draw         <= 1'b0;
        end else begin
            drop_req     <= '0;
            invalid_move <= 1'b0;
            board_clear  <= 1'b0;
            if (key_idle) begin
                armed_q <= 1'b1;
            end

            unique case (state_q)
                StReady: begin
                    if (armed_q && key_is_col) begin
                        armed_q <= 1'b0;
                        if (col_blocked) begin
                            invalid_move <= 1'b1;
                        end else begin
                            // Strobe is registered here so it lines up with the DROP cycle.
                            drop_req   <= 7'b1 << key_col;
                            drop_black <= turn_black;
                            state_q    <= StDrop;
                        end
                    end
                end

                StDrop: begin
                    move_count <= move_count + 6'd1;
                    wait_q     <= '0;
                    state_q    <= StSettle;
                end

                StSettle: begin
                    wait_q <= wait_q + 4'd1;
                    if (wait_q == LastWait) begin
                        state_q <= StEval;
                    end
                end

                StEval: begin
                    if (win_flag) begin
                        game_over    <= 1'b1;
                        winner_black <= turn_black;
                        state_q      <= StDone;
                    end else if (move_count == MaxMoves) begin
                        game_over <= 1'b1;
                        draw      <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        turn_black <= ~turn_black;
                        state_q    <= StReady;
                    end
                end

                StDone: begin
                    if (armed_q && key_newgame) begin
                        armed_q      <= 1'b0;
                        board_clear  <= 1'b1;
                        move_count   <= '0;
                        turn_black   <= 1'b0;
                        game_over    <= 1'b0;
                        winner_black <= 1'b0;
                        draw         <= 1'b0;
                        state_q      <= StReady;
                    end
                end

                default: begin
                    state_q <= StReady;
                end
            endcase
        end
    end

    drop_onehot: assert property (@(posedge frame_clk) $onehot0(drop_req));
    drop_in_drop_state: assert property (@(posedge frame_clk)
        (drop_req != 7'd0) |-> (state_q == StDrop));

endmodule

// File: tb/tb_c4_turn_controller.sv
// Self-checking bench for c4_turn_controller: directed scenarios plus random key/board/win
// stimulus compared against a move-level game model.
module tb_c4_turn_controller;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic [7:0] keycode   = 8'h00;
    logic [6:0] col_full  = 7'd0;
    logic       win_flag  = 1'b0;
    logic [6:0] drop_req;
    logic       drop_black;
    logic       turn_black;
    logic [5:0] move_count;
    logic       invalid_move;
    logic       board_clear;
    logic       game_over;
    logic       winner_black;
    logic       draw;

    c4_turn_controller #(
        .CHECK_CYCLES(2),
        .KEY_COL0    (8'h1E),
        .KEY_NEWGAME (8'h28)
    ) dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .col_full    (col_full),
        .win_flag    (win_flag),
        .drop_req    (drop_req),
        .drop_black  (drop_black),
        .turn_black  (turn_black),
        .move_count  (move_count),
        .invalid_move(invalid_move),
        .board_clear (board_clear),
        .game_over   (game_over),
        .winner_black(winner_black),
        .draw        (draw)
    );

    always #5 frame_clk = ~frame_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Game-level model state.
    bit m_turn;
    int m_count;
    bit m_over;
    bit m_winner;
    bit m_draw;

    // Observations collected over one key press.
    int         o_drops;
    int         o_inv;
    int         o_clr;
    logic [6:0] o_drop_val;
    logic       o_drop_black;

    // Expectations for one key press.
    logic [6:0] e_drop;
    bit         e_black;
    int         e_inv;
    int         e_clr;

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic model_reset();
        m_turn   = 0;
        m_count  = 0;
        m_over   = 0;
        m_winner = 0;
        m_draw   = 0;
    endtask

    task automatic model_press(input logic [7:0] key, input logic [6:0] full, input bit wf);
        int c;
        c       = int'(key) - 'h1E;
        e_drop  = 7'd0;
        e_black = 0;
        e_inv   = 0;
        e_clr   = 0;
        if (m_over) begin
            if (key == 8'h28) begin
                e_clr    = 1;
                m_over   = 0;
                m_count  = 0;
                m_turn   = 0;
                m_winner = 0;
                m_draw   = 0;
            end
        end else if (c >= 0 && c < 7) begin
            if (full[c]) begin
                e_inv = 1;
            end else begin
                e_drop  = 7'(1 << c);
                e_black = m_turn;
                m_count++;
                if (wf) begin
                    m_over   = 1;
                    m_winner = m_turn;
                end else if (m_count == 42) begin
                    m_over = 1;
                    m_draw = 1;
                end else begin
                    m_turn = !m_turn;
                end
            end
        end
    endtask

    // Release, press and hold one key for a fixed window that covers a whole move.
    task automatic press(input logic [7:0] key, input logic wf);
        keycode = 8'h00;
        tick();
        keycode      = key;
        win_flag     = wf;
        o_drops      = 0;
        o_inv        = 0;
        o_clr        = 0;
        o_drop_val   = 7'd0;
        o_drop_black = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (drop_req !== 7'd0) begin
                o_drops++;
                o_drop_val   = drop_req;
                o_drop_black = drop_black;
            end
            if (invalid_move === 1'b1) o_inv++;
            if (board_clear === 1'b1) o_clr++;
        end
        keycode  = 8'h00;
        win_flag = 1'b0;
    endtask

    task automatic do_reset();
        Reset   = 1'b1;
        keycode = 8'h00;
        tick();
        tick();
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [19:0] outs;
        Reset   = 1'b1;
        keycode = 8'h1E;
        tick();
        tick();
        tick();
        outs = {drop_req, drop_black, turn_black, move_count, invalid_move, board_clear,
                game_over, winner_black, draw};
        n_cmp++;
        if (outs !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        Reset   = 1'b0;
        o_drops = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (drop_req !== 7'd0) o_drops++;
        end
        n_cmp++;
        if (o_drops != 0) begin
            n_bad++;
            $display("FAIL reset_held_key: got %0d drops want 0", o_drops);
        end
        keycode = 8'h00;
        model_reset();
    endtask

    task automatic test_first_move();
        keycode = 8'h00;
        tick();
        keycode = 8'h20;
        tick();
        n_cmp++;
        if (drop_req !== 7'b0000100 || drop_black !== 1'b0) begin
            n_bad++;
            $display("FAIL first_drop: got %b/%b want 0000100/0", drop_req, drop_black);
        end
        tick();
        n_cmp++;
        if (drop_req !== 7'd0 || move_count !== 6'd1) begin
            n_bad++;
            $display("FAIL first_count: got drop %b count %0d want 0 / 1", drop_req, move_count);
        end
        tick();
        tick();
        n_cmp++;
        if (turn_black !== 1'b0) begin
            n_bad++;
            $display("FAIL turn_early: got %b want 0", turn_black);
        end
        tick();
        n_cmp++;
        if (turn_black !== 1'b1) begin
            n_bad++;
            $display("FAIL turn_toggle: got %b want 1", turn_black);
        end
        keycode = 8'h00;
        model_press(8'h20, 7'd0, 0);
    endtask

    task automatic test_hold();
        keycode = 8'h00;
        tick();
        keycode    = 8'h1E;
        o_drops    = 0;
        o_drop_val = 7'd0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (drop_req !== 7'd0) begin
                o_drops++;
                o_drop_val = drop_req;
            end
        end
        model_press(8'h1E, 7'd0, 0);
        n_cmp++;
        if (o_drops != 1 || o_drop_val !== e_drop) begin
            n_bad++;
            $display("FAIL hold_single: got %0d drops val %b want 1 val %b",
                     o_drops, o_drop_val, e_drop);
        end
        press(8'h1E, 1'b0);
        model_press(8'h1E, 7'd0, 0);
        n_cmp++;
        if (o_drops != 1 || o_drop_black !== e_black) begin
            n_bad++;
            $display("FAIL repress_colour: got %0d drops black %b want 1 black %b",
                     o_drops, o_drop_black, e_black);
        end
    endtask

    task automatic test_full_column();
        col_full = 7'b1000000;
        press(8'h24, 1'b0);
        model_press(8'h24, 7'b1000000, 0);
        col_full = 7'd0;
        n_cmp++;
        if (o_inv != 1 || o_drops != 0) begin
            n_bad++;
            $display("FAIL full_column: got inv %0d drops %0d want 1 / 0", o_inv, o_drops);
        end
        n_cmp++;
        if (turn_black !== m_turn || move_count !== 6'(m_count)) begin
            n_bad++;
            $display("FAIL full_unchanged: got turn %b count %0d want %b / %0d",
                     turn_black, move_count, m_turn, m_count);
        end
    endtask

    task automatic test_win();
        if (m_turn) begin
            press(8'h1F, 1'b0);
            model_press(8'h1F, 7'd0, 0);
        end
        press(8'h22, 1'b1);
        model_press(8'h22, 7'd0, 1);
        n_cmp++;
        if (game_over !== 1'b1 || winner_black !== 1'b0 || draw !== 1'b0) begin
            n_bad++;
            $display("FAIL red_win: got over %b winner %b draw %b want 1/0/0",
                     game_over, winner_black, draw);
        end
        press(8'h21, 1'b0);
        model_press(8'h21, 7'd0, 0);
        n_cmp++;
        if (o_drops != 0 || o_inv != 0) begin
            n_bad++;
            $display("FAIL done_ignores_col: got drops %0d inv %0d want 0 / 0", o_drops, o_inv);
        end
        press(8'h28, 1'b0);
        model_press(8'h28, 7'd0, 0);
        n_cmp++;
        if (o_clr != 1 || move_count !== 6'd0 || game_over !== 1'b0) begin
            n_bad++;
            $display("FAIL newgame: got clr %0d count %0d over %b want 1 / 0 / 0",
                     o_clr, move_count, game_over);
        end
        press(8'h1E, 1'b0);
        model_press(8'h1E, 7'd0, 0);
        n_cmp++;
        if (o_drops != 1 || o_drop_val !== 7'b0000001) begin
            n_bad++;
            $display("FAIL ready_after_new: got drops %0d val %b want 1 / 0000001",
                     o_drops, o_drop_val);
        end
    endtask

    task automatic test_draw_and_last_win();
        int total;
        do_reset();
        total = 0;
        for (int i = 0; i < 42; i++) begin
            press(8'(8'h1E + i % 7), 1'b0);
            total += o_drops;
        end
        n_cmp++;
        if (total != 42) begin
            n_bad++;
            $display("FAIL draw_drops: got %0d want 42", total);
        end
        n_cmp++;
        if (draw !== 1'b1 || game_over !== 1'b1 || winner_black !== 1'b0 ||
            move_count !== 6'd42) begin
            n_bad++;
            $display("FAIL draw_state: got draw %b over %b winner %b count %0d want 1/1/0/42",
                     draw, game_over, winner_black, move_count);
        end
        press(8'h28, 1'b0);
        for (int i = 0; i < 42; i++) begin
            press(8'(8'h1E + (i * 3) % 7), i == 41);
        end
        n_cmp++;
        if (draw !== 1'b0 || game_over !== 1'b1 || winner_black !== 1'b1) begin
            n_bad++;
            $display("FAIL win_on_42: got draw %b over %b winner %b want 0/1/1",
                     draw, game_over, winner_black);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_move();
        logic [19:0] outs;
        keycode = 8'h00;
        tick();
        keycode = 8'h22;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        outs = {drop_req, drop_black, turn_black, move_count, invalid_move, board_clear,
                game_over, winner_black, draw};
        n_cmp++;
        if (outs !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got %h want 0", outs);
        end
        Reset = 1'b0;
        model_reset();
        o_drops = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (drop_req !== 7'd0) o_drops++;
        end
        n_cmp++;
        if (o_drops != 0) begin
            n_bad++;
            $display("FAIL reset_mid_held: got %0d drops want 0", o_drops);
        end
        press(8'h22, 1'b0);
        model_press(8'h22, 7'd0, 0);
        n_cmp++;
        if (o_drops != 1 || o_drop_val !== e_drop || move_count !== 6'(m_count)) begin
            n_bad++;
            $display("FAIL reset_mid_rearm: got drops %0d val %b count %0d want 1 / %b / %0d",
                     o_drops, o_drop_val, move_count, e_drop, m_count);
        end
    endtask

    task automatic test_random();
        logic [7:0] key;
        logic [6:0] full;
        bit         wf;
        int         r;
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 11);
            if (r < 9) key = 8'(8'h1E + $urandom_range(0, 6));
            else if (r == 9) key = 8'h28;
            else key = 8'h05;
            full = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0;
            wf   = $urandom_range(0, 7) == 0;
            col_full = full;
            press(key, wf);
            model_press(key, full, wf);
            col_full = 7'd0;
            n_cmp++;
            if (o_drops != int'(e_drop != 7'd0) || o_drop_val !== e_drop) begin
                n_bad++;
                $display("FAIL rnd_drop[%0d]: got %0d drops val %b want val %b",
                         n, o_drops, o_drop_val, e_drop);
            end
            if (e_drop != 7'd0) begin
                n_cmp++;
                if (o_drop_black !== e_black) begin
                    n_bad++;
                    $display("FAIL rnd_colour[%0d]: got %b want %b", n, o_drop_black, e_black);
                end
            end
            n_cmp++;
            if (o_inv != e_inv || o_clr != e_clr) begin
                n_bad++;
                $display("FAIL rnd_pulses[%0d]: got inv %0d clr %0d want %0d / %0d",
                         n, o_inv, o_clr, e_inv, e_clr);
            end
            n_cmp++;
            if (turn_black !== m_turn || move_count !== 6'(m_count) || game_over !== m_over ||
                draw !== m_draw || winner_black !== m_winner) begin
                n_bad++;
                $display("FAIL rnd_state[%0d]: got t%b c%0d o%b d%b w%b want t%b c%0d o%b d%b w%b",
                         n, turn_black, move_count, game_over, draw, winner_black,
                         m_turn, m_count, m_over, m_draw, m_winner);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_first_move();
        test_hold();
        test_full_column();
        test_win();
        test_draw_and_last_win();
        test_reset_mid_move();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
